// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, request header, address check.
// The byte-lane build option (DMEM_BYTE_LANE_EN) is handled in the modules, not here.
package data_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int ADDR_BITS = 16;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
  } req_hdr_t;

  // Reject odd byte addresses and anything above the last word of a 2**aw-word array.
  function automatic logic addr_bad(input logic [ADDR_BITS-1:0] a, input int unsigned aw);
    logic [ADDR_BITS-1:0] hi;
    hi = a >> (aw + 1);
    return a[0] | (hi != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage: synchronous write (optional byte lanes under DMEM_BYTE_LANE_EN), registered read.
// Latency: one edge for both write and read capture; no backpressure, caller strobes wen/ren.
// rdata resets to zero and otherwise holds until the next ren; the array itself is never cleared.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [1:0]        be,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] wmask;

  always_comb begin
    wmask = '1;
`ifdef DMEM_BYTE_LANE_EN
    for (int i = 0; i < DATA_W; i++) begin
      wmask[i] = (i < 8) ? be[0] : be[1];
    end
`endif
  end

  // Kept free of reset so that a reset never disturbs stored contents.
  always_ff @(posedge clock) begin
    if (wen) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for LW/SW: latch request, wait, commit, pulse ready (DMEM_BYTE_LANE_EN adds be).
// Latency: req accepted at edge N gives ready in the cycle after edge N+WAIT_CYCLES+1.
// Backpressure: busy from accept through ready; requests only taken in IDLE or on the edge leaving RESP.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [1:0]        be,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              err_q;
  req_hdr_t          hdr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              commit;
  logic              bad;
`ifdef DMEM_BYTE_LANE_EN
  logic [1:0]        be_q;
`endif

  assign accept = req && (state == ST_IDLE || state == ST_RESP);
  assign commit = (state == ST_WAIT) && (cnt == WAIT_LAST);
  assign bad    = addr_bad(hdr_q.addr, ADDR_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      hdr_q   <= '0;
      wdata_q <= '0;
`ifdef DMEM_BYTE_LANE_EN
      be_q    <= '0;
`endif
    end else begin
      if (accept) begin
        hdr_q   <= '{we: we, addr: addr};
        wdata_q <= wdata;
`ifdef DMEM_BYTE_LANE_EN
        be_q    <= be;
`endif
      end
      // The first WAIT cycle is the capture cycle, so WAIT lasts WAIT_CYCLES+1 cycles.
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state <= ST_RESP;
            err_q <= bad;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          err_q <= 1'b0;
          cnt   <= '0;
          state <= accept ? ST_WAIT : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state == ST_RESP);
  assign busy  = (state != ST_IDLE);
  assign err   = ready & err_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .wen   (commit & hdr_q.we & ~bad),
    .ren   (commit & ~hdr_q.we & ~bad),
    .idx   (hdr_q.addr[ADDR_W:1]),
    .wdata (wdata_q),
`ifdef DMEM_BYTE_LANE_EN
    .be    (be_q),
`endif
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3) against an array-based model.
// Define DMEM_BYTE_LANE_EN to also exercise byte-lane stores.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_s   [3];
  logic        req_s   [3];
  logic        we_s    [3];
  logic [15:0] addr_s  [3];
  logic [15:0] wdata_s [3];
  logic [1:0]  be_s    [3];
  logic [15:0] rdata_s [3];
  logic        ready_s [3];
  logic        busy_s  [3];
  logic        err_s   [3];

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance word array, written flags, last load value.
  logic [15:0] mdl_mem [3][256];
  bit          mdl_val [3][256];
  logic [15:0] mdl_rd  [3];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(1)) dut0 (
    .clock(clk), .reset(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]),
`ifdef DMEM_BYTE_LANE_EN
    .be(be_s[0]),
`endif
    .rdata(rdata_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0]));

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clock(clk), .reset(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]),
`ifdef DMEM_BYTE_LANE_EN
    .be(be_s[1]),
`endif
    .rdata(rdata_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1]));

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(3)) dut2 (
    .clock(clk), .reset(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]),
`ifdef DMEM_BYTE_LANE_EN
    .be(be_s[2]),
`endif
    .rdata(rdata_s[2]), .ready(ready_s[2]), .busy(busy_s[2]), .err(err_s[2]));

  function automatic int wait_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble(input int k);
    we_s[k]    = 1'($urandom);
    addr_s[k]  = 16'($urandom);
    wdata_s[k] = 16'($urandom);
    be_s[k]    = 2'($urandom);
  endtask

  // One access: drive on a falling edge, check every cycle up to and including the ready cycle.
  // With hold=1 req stays high so the caller's next access is accepted on the edge leaving RESP.
  task automatic txn(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b, input bit hold);
    logic        exp_err;
    logic [7:0]  word;
    logic [15:0] mask;
    int          wc;
    wc      = wait_of(k);
    exp_err = a[0] || (a[15:9] != 7'd0);
    word    = a[8:1];
`ifdef DMEM_BYTE_LANE_EN
    mask = {{8{b[1]}}, {8{b[0]}}};
`else
    mask = 16'hFFFF;
`endif
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b;
    @(posedge clk); #1;
    if (!hold) req_s[k] = 1'b0;
    scramble(k);
    chk($sformatf("busy_accept_i%0d", k), 16'(busy_s[k]), 16'd1);
    chk($sformatf("ready_accept_i%0d", k), 16'(ready_s[k]), 16'd0);
    for (int c = 1; c <= wc + 1; c++) begin
      @(posedge clk); #1;
      scramble(k);
      if (c <= wc) begin
        chk($sformatf("ready_wait_i%0d_c%0d", k, c), 16'(ready_s[k]), 16'd0);
        chk($sformatf("busy_wait_i%0d_c%0d", k, c), 16'(busy_s[k]), 16'd1);
      end
    end
    if (!exp_err && w) begin
      mdl_mem[k][word] = (mdl_mem[k][word] & ~mask) | (d & mask);
      if (mask == 16'hFFFF) mdl_val[k][word] = 1'b1;
    end
    if (!exp_err && !w) mdl_rd[k] = mdl_mem[k][word];
    chk($sformatf("ready_resp_i%0d_a%04h", k, a), 16'(ready_s[k]), 16'd1);
    chk($sformatf("busy_resp_i%0d_a%04h", k, a), 16'(busy_s[k]), 16'd1);
    chk($sformatf("err_resp_i%0d_a%04h", k, a), 16'(err_s[k]), 16'(exp_err));
    chk($sformatf("rdata_resp_i%0d_a%04h", k, a), rdata_s[k], mdl_rd[k]);
    if (!hold) begin
      @(posedge clk); #1;
      chk($sformatf("ready_after_i%0d", k), 16'(ready_s[k]), 16'd0);
      chk($sformatf("err_after_i%0d", k), 16'(err_s[k]), 16'd0);
      chk($sformatf("busy_after_i%0d", k), 16'(busy_s[k]), 16'd0);
    end
  endtask

  task automatic rand_run(input int k, input int n);
    logic [7:0]  word;
    logic [15:0] a;
    logic        w;
    bit          hold;
    for (int i = 0; i < n; i++) begin
      word = 8'($urandom_range(0, 31));
      a    = {7'd0, word, 1'b0};
      case ($urandom_range(0, 9))
        0: a[0] = 1'b1;
        1: a[15:9] = 7'($urandom_range(1, 127));
        default: ;
      endcase
      w = 1'($urandom);
      if (!w && !mdl_val[k][word] && !(a[0] || a[15:9] != 7'd0)) w = 1'b1;
      hold = (i != n - 1) && ($urandom_range(0, 3) == 0);
      txn(k, w, a, 16'($urandom), 2'($urandom), hold);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; we_s[k] = 1'b0;
      addr_s[k] = '0; wdata_s[k] = '0; be_s[k] = 2'b11; mdl_rd[k] = '0;
      for (int j = 0; j < 256; j++) begin
        mdl_val[k][j] = 1'b0;
        mdl_mem[k][j] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ready_i%0d", k), 16'(ready_s[k]), 16'd0);
      chk($sformatf("reset_busy_i%0d", k), 16'(busy_s[k]), 16'd0);
      chk($sformatf("reset_err_i%0d", k), 16'(err_s[k]), 16'd0);
      chk($sformatf("reset_rdata_i%0d", k), rdata_s[k], 16'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;

    // Store then load, two-cycle response
    txn(0, 1'b1, 16'h0010, 16'h00F7, 2'b11, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0);
    chk("sw_lw_0x0010", rdata_s[0], 16'h00F7);

    // Misaligned and out-of-range accesses
    txn(0, 1'b1, 16'h0000, 16'hBEEF, 2'b11, 1'b0);
    txn(0, 1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0);
    txn(0, 1'b1, 16'h0200, 16'hDEAD, 2'b11, 1'b0);
    txn(0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0);
    chk("word0_unchanged", rdata_s[0], 16'hBEEF);

    // Back-to-back loads with req held, zero wait states
    txn(1, 1'b1, 16'h0004, 16'h1111, 2'b11, 1'b0);
    txn(1, 1'b1, 16'h0006, 16'h2222, 2'b11, 1'b0);
    txn(1, 1'b0, 16'h0004, 16'h0000, 2'b11, 1'b1);
    txn(1, 1'b0, 16'h0006, 16'h0000, 2'b11, 1'b0);
    chk("b2b_second_load", rdata_s[1], 16'h2222);

    // Reset during WAIT drops the pending store
    txn(2, 1'b1, 16'h0020, 16'h5555, 2'b11, 1'b0);
    txn(2, 1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0);
    @(negedge clk);
    req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 16'h0020; wdata_s[2] = 16'h1234; be_s[2] = 2'b11;
    @(posedge clk); #1;
    req_s[2] = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_busy", 16'(busy_s[2]), 16'd1);
    rst_s[2] = 1'b1;
    #1;
    chk("rst_wait_busy", 16'(busy_s[2]), 16'd0);
    chk("rst_wait_ready", 16'(ready_s[2]), 16'd0);
    chk("rst_wait_err", 16'(err_s[2]), 16'd0);
    chk("rst_wait_rdata", rdata_s[2], 16'd0);
    mdl_rd[2] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s[2] = 1'b0;
    txn(2, 1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0);
    chk("store_dropped", rdata_s[2], 16'h5555);

`ifdef DMEM_BYTE_LANE_EN
    txn(0, 1'b1, 16'h0030, 16'hAAAA, 2'b11, 1'b0);
    txn(0, 1'b1, 16'h0030, 16'h1234, 2'b01, 1'b0);
    txn(0, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0);
    chk("lane_low_only", rdata_s[0], 16'hAA34);
    txn(0, 1'b1, 16'h0030, 16'h5678, 2'b00, 1'b0);
    txn(0, 1'b0, 16'h0030, 16'h0000, 2'b10, 1'b0);
    chk("lane_none", rdata_s[0], 16'hAA34);
`endif

    // Randomized traffic; busy-time inputs are scrambled inside every access
    for (int k = 0; k < 3; k++) rand_run(k, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
